gpio_pin_arbiter: RTL and testbench
===================================

Name: gpio_pin_arbiter

Overview:
Shares the 36 user GPIO pads between NSRC internal requesters, each of which presents a full io_out/io_oeb vector. A per-pin owner table, written through a simple config port, selects which requester drives each pad. When ownership changes, the pin is forced hi-Z for GUARD cycles so two requesters never drive it back-to-back. The block sits between the requesters and the pad-level io_out/io_oeb/io_in signals of the user project.

Parameters:
NPINS, 36, number of GPIO pads
NSRC, 4, number of requesters; owner ids 0..NSRC-1
SW, 2, owner id width, must equal clog2(NSRC)
GUARD, 2, forced hi-Z cycles on an ownership change; minimum 1

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
cfg_we_i  input  1  config write strobe
cfg_addr_i  input  6  pin index to reassign
cfg_wdata_i  input  SW  new owner id
cfg_busy_o  output  1  guard sequence in progress
cfg_err_o  output  1  one-cycle pulse when a write is rejected
cfg_owner_o  output  SW  current owner of the pin at cfg_addr_i (combinational readback)
src_out_i  input  NSRC*NPINS  requester output values; requester s, pin p is bit s*NPINS+p
src_oeb_i  input  NSRC*NPINS  requester output-enable-bar, same packing
src_in_o  output  NSRC*NPINS  gated pad inputs returned to the requesters, same packing
io_out_o  output  NPINS  pad output value (registered)
io_oeb_o  output  NPINS  pad output-enable-bar, 1 = hi-Z (registered)
io_in_i  input  NPINS  pad input value

Behaviour:
- One clock domain, clk_i. All state resets synchronously while rst_i is high.
- Reset values:
  - all owner[p] = 0
  - FSM in IDLE
  - io_oeb_o = all 1, io_out_o = all 0
  - cfg_busy_o = 0, cfg_err_o = 0
- First cycle after reset release: outputs follow requester 0 with one cycle of latency.
- Steady-state output path (registered, 1-cycle latency):
  - io_out_o[p] <= src_out_i[owner[p]*NPINS+p]
  - io_oeb_o[p] <= src_oeb_i[owner[p]*NPINS+p]
- Input path (combinational): src_in_o[s*NPINS+p] = io_in_i[p] when owner[p]==s and pin p is not guarding; otherwise 0.
- FSM states: IDLE and GUARD. There is a guard-cycle counter gcnt and latched registers gpin and gnew.
- Write handling in IDLE, when cfg_we_i=1:
  - cfg_addr_i >= NPINS or cfg_wdata_i >= NSRC: the write is rejected. cfg_err_o pulses for 1 cycle and no state changes.
  - cfg_wdata_i == owner[cfg_addr_i]: no-op. No error, no guard.
  - Otherwise, at accepting edge k: latch gpin and gnew, set gcnt = GUARD, go to GUARD.
- GUARD state:
  - cfg_busy_o = 1.
  - On each edge, io_oeb_o[gpin] <= 1 and io_out_o[gpin] <= 0, so the pad is hi-Z during cycles k+1..k+GUARD.
  - src_in_o is 0 for gpin for every requester.
  - gcnt decrements each edge.
  - On the edge where gcnt==1: owner[gpin] <= gnew and the FSM returns to IDLE.
  - The new owner's values appear on the pad from edge k+GUARD+1.
- Other pins are unaffected by a guard sequence and keep tracking their owners every cycle.
- A write arriving while busy is rejected: cfg_err_o pulses and the in-flight sequence continues.
- cfg_owner_o returns the committed owner; it shows the old owner until the commit edge.
- rst_i asserted mid-GUARD aborts the sequence. All owners return to 0 and all pads go hi-Z on the next edge.
- Exactly one reassignment is in flight at a time. There is no queueing.

Test Plan:
- Reset: hold rst_i 3 cycles, requester 0 drives src_oeb=0 and src_out=all 1 → io_oeb_o=all 1 during reset; io_out_o=all 1 and io_oeb_o=0 one cycle after release.
- Reassign pin 5 to owner 2 with GUARD=2, write at edge k → io_oeb_o[5]=1 at k+1 and k+2; cfg_busy_o high 2 cycles; from k+3 pin 5 follows requester 2; pins 0-4 and 6-35 never glitch.
- Input gating: io_in_i[7]=1 with pin 7 owned by 1 → src_in_o bit 1*36+7 = 1; bits 0*36+7, 2*36+7 and 3*36+7 = 0; during a guard on pin 7 all four bits = 0.
- Error cases: address 36 → cfg_err_o pulse, no change; owner id 3 with NSRC=3 → pulse; write during busy → pulse and the original sequence completes unchanged.
- Same-owner write to pin 10 (owner 0 → 0) → no busy, no error, no hi-Z cycle on pin 10.
- Reset during GUARD on pin 20 → next edge: owner[20]=0, busy=0, all io_oeb_o=1.

Source files
------------

// File: rtl/gpio_pin_arbiter_if.sv
// Config port of the GPIO pin arbiter: owner-table write strobe, owner readback, busy/error status.
// The arbiter takes the slave modport; whatever writes the owner table takes the master modport.
interface gpio_pin_arbiter_if #(
  parameter int SW = 2
);
  logic          cfg_we;
  logic [5:0]    cfg_addr;
  logic [SW-1:0] cfg_wdata;
  logic          cfg_busy;
  logic          cfg_err;
  logic [SW-1:0] cfg_owner;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata,
    input  cfg_busy, cfg_err, cfg_owner
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata,
    output cfg_busy, cfg_err, cfg_owner
  );
endinterface

// File: rtl/gpio_pin_arbiter.sv
// Per-pin owner mux from NSRC requesters onto the GPIO pads, 1-cycle registered pad outputs.
// Owner changes force the pin hi-Z for GUARD cycles; writes made while busy are rejected with an error pulse.
module gpio_pin_arbiter #(
  parameter int NPINS = 36,
  parameter int NSRC  = 4,
  parameter int SW    = 2,
  parameter int GUARD = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  gpio_pin_arbiter_if.slave     cfg,
  input  logic [NSRC*NPINS-1:0] src_out_i,
  input  logic [NSRC*NPINS-1:0] src_oeb_i,
  output logic [NSRC*NPINS-1:0] src_in_o,
  output logic [NPINS-1:0]      io_out_o,
  output logic [NPINS-1:0]      io_oeb_o,
  input  logic [NPINS-1:0]      io_in_i
);

  localparam int AW = 6;
  localparam int GW = $clog2(GUARD + 1);

  typedef enum logic {S_IDLE, S_GUARD} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    owner_q [NPINS];
  logic [SW-1:0]    owner_d [NPINS];
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [AW-1:0]    gpin_q, gpin_d;
  logic [SW-1:0]    gnew_q, gnew_d;
  logic [NPINS-1:0] io_out_q, io_out_d;
  logic [NPINS-1:0] io_oeb_q, io_oeb_d;
  logic             err_q, err_d;

  logic             guarding;
  logic             addr_ok;
  logic             data_ok;
  logic [SW-1:0]    cur_owner;

  assign guarding  = (state_q == S_GUARD);
  assign addr_ok   = int'(cfg.cfg_addr) < NPINS;
  assign data_ok   = int'(cfg.cfg_wdata) < NSRC;
  assign cur_owner = addr_ok ? owner_q[cfg.cfg_addr] : '0;

  assign cfg.cfg_busy  = guarding;
  assign cfg.cfg_err   = err_q;
  assign cfg.cfg_owner = cur_owner;
  assign io_out_o      = io_out_q;
  assign io_oeb_o      = io_oeb_q;

  // Pad inputs reach only the committed owner, and nobody while the pin is guarding.
  always_comb begin
    src_in_o = '0;
    for (int s = 0; s < NSRC; s++) begin
      for (int p = 0; p < NPINS; p++) begin
        src_in_o[s*NPINS+p] = io_in_i[p] && (owner_q[p] == SW'(s))
                              && !(guarding && (gpin_q == AW'(p)));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    gcnt_d  = gcnt_q;
    gpin_d  = gpin_q;
    gnew_d  = gnew_q;
    err_d   = 1'b0;

    for (int p = 0; p < NPINS; p++) begin
      if (guarding && (gpin_q == AW'(p))) begin
        io_out_d[p] = 1'b0;
        io_oeb_d[p] = 1'b1;
      end else begin
        io_out_d[p] = src_out_i[int'(owner_q[p])*NPINS + p];
        io_oeb_d[p] = src_oeb_i[int'(owner_q[p])*NPINS + p];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cfg.cfg_we) begin
          if (!addr_ok || !data_ok) begin
            err_d = 1'b1;
          end else if (cfg.cfg_wdata != cur_owner) begin
            gpin_d  = cfg.cfg_addr;
            gnew_d  = cfg.cfg_wdata;
            gcnt_d  = GW'(GUARD);
            state_d = S_GUARD;
          end
        end
      end
      S_GUARD: begin
        err_d  = cfg.cfg_we;
        gcnt_d = gcnt_q - 1'b1;
        if (gcnt_q == GW'(1)) begin
          owner_d[gpin_q] = gnew_q;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      owner_q  <= '{default: '0};
      gcnt_q   <= '0;
      gpin_q   <= '0;
      gnew_q   <= '0;
      io_out_q <= '0;
      io_oeb_q <= '1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      gcnt_q   <= gcnt_d;
      gpin_q   <= gpin_d;
      gnew_q   <= gnew_d;
      io_out_q <= io_out_d;
      io_oeb_q <= io_oeb_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_gpio_pin_arbiter.sv
// Directed bench for gpio_pin_arbiter: reset, guarded reassignment, input gating, error and abort cases.
module tb_gpio_pin_arbiter;
  localparam int NP = 36;

  logic                clk = 1'b0;
  logic                rst;
  logic [4*NP-1:0]     src_out, src_oeb, src_in;
  logic [NP-1:0]       io_out, io_oeb, io_in;
  logic [3*NP-1:0]     s3_out, s3_oeb, s3_in;
  logic [NP-1:0]       io3_out, io3_oeb, io3_in;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [NP-1:0] ONES = '1;
  localparam logic [NP-1:0] PAT3 = 36'h5_5555_5555;

  gpio_pin_arbiter_if #(.SW(2)) cif ();
  gpio_pin_arbiter_if #(.SW(2)) cif3 ();

  gpio_pin_arbiter #(.NPINS(NP), .NSRC(4), .SW(2), .GUARD(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .cfg(cif.slave),
    .src_out_i(src_out), .src_oeb_i(src_oeb), .src_in_o(src_in),
    .io_out_o(io_out), .io_oeb_o(io_oeb), .io_in_i(io_in)
  );

  gpio_pin_arbiter #(.NPINS(NP), .NSRC(3), .SW(2), .GUARD(2)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .cfg(cif3.slave),
    .src_out_i(s3_out), .src_oeb_i(s3_oeb), .src_in_o(s3_in),
    .io_out_o(io3_out), .io_oeb_o(io3_oeb), .io_in_i(io3_in)
  );

  always #5 clk = ~clk;

  function automatic logic [NP-1:0] pb(input int p);
    logic [NP-1:0] v;
    v    = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4*NP-1:0] obs, input logic [4*NP-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input int data);
    cif.cfg_we    = 1'b1;
    cif.cfg_addr  = 6'(addr);
    cif.cfg_wdata = 2'(data);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cif.cfg_we = 1'b0; cif.cfg_addr = 6'd5; cif.cfg_wdata = '0;
    cif3.cfg_we = 1'b0; cif3.cfg_addr = '0; cif3.cfg_wdata = '0;
    s3_out = '0; s3_oeb = '0; io3_in = '0;
    io_in = '0;
    // requester 0: drive all 1; 1: hi-Z; 2: drive all 0; 3: drive 0x5..5
    src_out = {PAT3, {NP{1'b0}}, {NP{1'b0}}, ONES};
    src_oeb = {{NP{1'b0}}, {NP{1'b0}}, ONES, {NP{1'b0}}};

    // reset held 3 cycles
    tick(); tick(); tick();
    chk("rst_oeb", io_oeb, ONES);
    chk("rst_out", io_out, '0);
    chk("rst_busy", cif.cfg_busy, 1'b0);
    chk("rst_err", cif.cfg_err, 1'b0);
    chk("rst_owner", cif.cfg_owner, 2'd0);
    rst = 1'b0;
    tick();
    chk("rel_out", io_out, ONES);
    chk("rel_oeb", io_oeb, '0);

    // reassign pin 5 to requester 2; edge k is the next tick
    wr(5, 2);
    tick();
    cif.cfg_we = 1'b0;
    chk("k_busy", cif.cfg_busy, 1'b1);
    chk("k_oeb", io_oeb, '0);
    chk("k_owner", cif.cfg_owner, 2'd0);
    tick();
    chk("k1_oeb", io_oeb, pb(5));
    chk("k1_out", io_out, ONES & ~pb(5));
    chk("k1_busy", cif.cfg_busy, 1'b1);
    chk("k1_owner", cif.cfg_owner, 2'd0);
    tick();
    chk("k2_oeb", io_oeb, pb(5));
    chk("k2_out", io_out, ONES & ~pb(5));
    chk("k2_busy", cif.cfg_busy, 1'b0);
    chk("k2_owner", cif.cfg_owner, 2'd2);
    tick();
    chk("k3_oeb", io_oeb, '0);
    chk("k3_out", io_out, ONES & ~pb(5));

    // input gating on pin 7, moved from requester 0 to 1
    io_in = pb(7);
    #1;
    chk("gate_own0", src_in, {{3*NP{1'b0}}, pb(7)});
    wr(7, 1);
    tick();
    cif.cfg_we = 1'b0;
    chk("gate_k", src_in, '0);
    tick();
    chk("gate_k1", src_in, '0);
    tick();
    chk("gate_own1", src_in, {{2*NP{1'b0}}, pb(7), {NP{1'b0}}});
    io_in = '0;

    // bad address
    wr(36, 1);
    tick();
    cif.cfg_we = 1'b0;
    chk("addr_err", cif.cfg_err, 1'b1);
    chk("addr_busy", cif.cfg_busy, 1'b0);
    cif.cfg_addr = 6'd5;
    tick();
    chk("addr_err_clr", cif.cfg_err, 1'b0);
    chk("addr_nochg", cif.cfg_owner, 2'd2);

    // owner id out of range with NSRC=3, then a legal one
    cif3.cfg_we = 1'b1; cif3.cfg_addr = 6'd0; cif3.cfg_wdata = 2'd3;
    tick();
    cif3.cfg_we = 1'b0;
    chk("id3_err", cif3.cfg_err, 1'b1);
    chk("id3_busy", cif3.cfg_busy, 1'b0);
    tick();
    chk("id3_err_clr", cif3.cfg_err, 1'b0);
    chk("id3_owner", cif3.cfg_owner, 2'd0);
    cif3.cfg_we = 1'b1; cif3.cfg_wdata = 2'd2;
    tick();
    cif3.cfg_we = 1'b0;
    chk("id2_err", cif3.cfg_err, 1'b0);
    chk("id2_busy", cif3.cfg_busy, 1'b1);

    // write while busy: pin 12 -> 3, intruding write to 12 -> 1
    wr(12, 3);
    tick();
    wr(12, 1);
    tick();
    cif.cfg_we = 1'b0;
    chk("busy_err", cif.cfg_err, 1'b1);
    chk("busy_busy", cif.cfg_busy, 1'b1);
    chk("busy_oeb", io_oeb, pb(12) | pb(7));
    tick();
    chk("busy_err_clr", cif.cfg_err, 1'b0);
    chk("busy_done", cif.cfg_busy, 1'b0);
    chk("busy_owner", cif.cfg_owner, 2'd3);
    tick();
    chk("busy_out", io_out, ONES & ~pb(5) & ~pb(7));
    chk("busy_oeb_end", io_oeb, pb(7));

    // same-owner write on pin 10
    wr(10, 0);
    tick();
    cif.cfg_we = 1'b0;
    chk("same_busy", cif.cfg_busy, 1'b0);
    chk("same_err", cif.cfg_err, 1'b0);
    tick();
    chk("same_oeb", io_oeb, pb(7));

    // reset in the middle of a guard on pin 20
    wr(20, 3);
    tick();
    cif.cfg_we = 1'b0;
    cif.cfg_addr = 6'd20;
    tick();
    chk("abort_pre_oeb", io_oeb, pb(7) | pb(20));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_owner20", cif.cfg_owner, 2'd0);
    chk("abort_busy", cif.cfg_busy, 1'b0);
    chk("abort_oeb", io_oeb, ONES);
    chk("abort_out", io_out, '0);
    cif.cfg_addr = 6'd5;
    #1;
    chk("abort_owner5", cif.cfg_owner, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
